// File: rtl/ddr_arbiter.sv
// ddr_arbiter
//   Shares one DDR3 Avalon-style port between two burst-read clients
//   (client 0: 68k program ROM fetch, client 1: graphics/sprite ROM fetch)
//   and the ROM download write channel. Transactions are serialised with a
//   registered grant, and returning read beats are routed to the granted
//   client.
//
//   Build option: DDR_ARB_DOWNLOAD_EN
//     defined   - download write channel, WR_REQ state and download priority
//     undefined - no write path: ddr_wr/ddr_din/ddr_mask tie to 0,
//                 dl_waitreq ties to 0 (writes are dropped, never stalled)
//
//   Handshake: a requester raises its strobe with address/burst/data and holds
//   them until it sees its waitreq low; the cycle in which waitreq is low is
//   the single acceptance cycle. Towards DDR the same rule applies: a command
//   is accepted in a cycle where ddr_rd/ddr_wr is high and ddr_waitreq is low,
//   and every command output is held stable until then.
//
//   Ports
//     clk_sys, rst_n                  clock, asynchronous active-low reset
//     c0_* / c1_*                     client read request, address, burst,
//                                     waitreq and per-client beat valid
//     cx_dout                         shared read data (same as ddr_dout)
//     dl_wr/dl_addr/dl_din/dl_mask    single-beat download write request
//     dl_waitreq                      download acceptance (low one cycle)
//     ddr_*                           DDR command and read-return port
//     dbg_state                       current FSM state (IDLE=0, RD_REQ=1,
//                                     RD_DATA=2, WR_REQ=3)
module ddr_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int BURST_W = 8
) (
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic                c0_rd,
  input  logic [ADDR_W-1:0]   c0_addr,
  input  logic [BURST_W-1:0]  c0_burst,
  output logic                c0_waitreq,
  output logic                c0_valid,
  input  logic                c1_rd,
  input  logic [ADDR_W-1:0]   c1_addr,
  input  logic [BURST_W-1:0]  c1_burst,
  output logic                c1_waitreq,
  output logic                c1_valid,
  output logic [DATA_W-1:0]   cx_dout,
  input  logic                dl_wr,
  input  logic [ADDR_W-1:0]   dl_addr,
  input  logic [DATA_W-1:0]   dl_din,
  input  logic [DATA_W/8-1:0] dl_mask,
  output logic                dl_waitreq,
  output logic                ddr_rd,
  output logic                ddr_wr,
  output logic [ADDR_W-1:0]   ddr_addr,
  output logic [BURST_W-1:0]  ddr_burst,
  output logic [DATA_W-1:0]   ddr_din,
  output logic [DATA_W/8-1:0] ddr_mask,
  input  logic [DATA_W-1:0]   ddr_dout,
  input  logic                ddr_waitreq,
  input  logic                ddr_valid,
  output logic [1:0]          dbg_state
);

`ifdef DDR_ARB_DOWNLOAD_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_DATA = 2'd2,
    WR_REQ  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_DATA = 2'd2
  } state_t;
`endif

  state_t             state;
  logic               grant;       // client owning the current read (0/1)
  logic               last_grant;  // client granted by the previous read
  logic               rd_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [BURST_W-1:0] burst_q;
  logic [BURST_W-1:0] beat_cnt;    // beats still to come in RD_DATA
  logic               win;         // read arbitration winner this cycle
  logic               rd_acc;      // DDR accepts the read command this cycle

  // On a tie the client that did not win last time goes; otherwise whichever
  // single client is requesting (only meaningful when one of them is).
  assign win    = (c0_rd && c1_rd) ? ~last_grant : c1_rd;
  assign rd_acc = (state == RD_REQ) && !ddr_waitreq;

  assign c0_waitreq = ~(rd_acc && !grant);
  assign c1_waitreq = ~(rd_acc && grant);

  // Beats are only routed while a read is outstanding; strays are dropped.
  assign c0_valid = (state == RD_DATA) && ddr_valid && !grant;
  assign c1_valid = (state == RD_DATA) && ddr_valid && grant;
  assign cx_dout  = ddr_dout;

  assign ddr_rd    = rd_q;
  assign ddr_addr  = addr_q;
  assign ddr_burst = burst_q;
  assign dbg_state = state;

`ifdef DDR_ARB_DOWNLOAD_EN
  logic                wr_q;
  logic [DATA_W-1:0]   din_q;
  logic [DATA_W/8-1:0] mask_q;

  assign ddr_wr     = wr_q;
  assign ddr_din    = din_q;
  assign ddr_mask   = mask_q;
  assign dl_waitreq = ~((state == WR_REQ) && !ddr_waitreq);
`else
  logic unused_dl;

  assign ddr_wr     = 1'b0;
  assign ddr_din    = '0;
  assign ddr_mask   = '0;
  assign dl_waitreq = 1'b0;
  assign unused_dl  = ^{dl_wr, dl_addr, dl_din, dl_mask};
`endif

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;  // client 0 wins the first tie
      rd_q       <= 1'b0;
      addr_q     <= '0;
      burst_q    <= '0;
      beat_cnt   <= '0;
`ifdef DDR_ARB_DOWNLOAD_EN
      wr_q       <= 1'b0;
      din_q      <= '0;
      mask_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef DDR_ARB_DOWNLOAD_EN
          // Downloads win outright; the CPU is held in reset meanwhile, so
          // starving reads is harmless.
          if (dl_wr) begin
            addr_q  <= dl_addr;
            burst_q <= BURST_W'(1);
            din_q   <= dl_din;
            mask_q  <= dl_mask;
            wr_q    <= 1'b1;
            state   <= WR_REQ;
          end else
`endif
          if (c0_rd || c1_rd) begin
            grant   <= win;
            addr_q  <= win ? c1_addr : c0_addr;
            burst_q <= win ? c1_burst : c0_burst;
            rd_q    <= 1'b1;
            state   <= RD_REQ;
          end
        end

        RD_REQ: begin
          if (!ddr_waitreq) begin
            rd_q       <= 1'b0;
            // A zero burst still returns one beat.
            beat_cnt   <= (burst_q == '0) ? BURST_W'(1) : burst_q;
            last_grant <= grant;
            state      <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (ddr_valid) begin
            beat_cnt <= beat_cnt - BURST_W'(1);
            if (beat_cnt == BURST_W'(1)) begin
              state <= IDLE;
            end
          end
        end

`ifdef DDR_ARB_DOWNLOAD_EN
        WR_REQ: begin
          if (!ddr_waitreq) begin
            wr_q  <= 1'b0;
            state <= IDLE;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_arbiter.sv
// tb_ddr_arbiter
//   Bench for ddr_arbiter. The bench plays both the clients and the DDR
//   device. Every read beat it returns is pushed to exp_q as {client, data};
//   a negedge monitor pops and compares each client valid beat. Build with or
//   without DDR_ARB_DOWNLOAD_EN to exercise the matching configuration.
module tb_ddr_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int BURST_W = 8;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_REQ  = 2'd1;
  localparam logic [1:0] ST_RD_DATA = 2'd2;
`ifdef DDR_ARB_DOWNLOAD_EN
  localparam logic DL_WAIT_RST = 1'b1;
`else
  localparam logic DL_WAIT_RST = 1'b0;
`endif

  logic                clk_sys = 1'b0;
  logic                rst_n = 1'b0;
  logic                c0_rd = 1'b0, c1_rd = 1'b0;
  logic [ADDR_W-1:0]   c0_addr = '0, c1_addr = '0;
  logic [BURST_W-1:0]  c0_burst = '0, c1_burst = '0;
  logic                c0_waitreq, c1_waitreq, c0_valid, c1_valid;
  logic [DATA_W-1:0]   cx_dout;
  logic                dl_wr = 1'b0;
  logic [ADDR_W-1:0]   dl_addr = '0;
  logic [DATA_W-1:0]   dl_din = '0;
  logic [DATA_W/8-1:0] dl_mask = '0;
  logic                dl_waitreq;
  logic                ddr_rd, ddr_wr;
  logic [ADDR_W-1:0]   ddr_addr;
  logic [BURST_W-1:0]  ddr_burst;
  logic [DATA_W-1:0]   ddr_din;
  logic [DATA_W/8-1:0] ddr_mask;
  logic [DATA_W-1:0]   ddr_dout = '0;
  logic                ddr_waitreq = 1'b0;
  logic                ddr_valid = 1'b0;
  logic [1:0]          dbg_state;

  int checks = 0;
  int errors = 0;
  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] mon_got, mon_exp;
  logic [120:0]    rst_vec, rst_exp;

  ddr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .c0_rd(c0_rd), .c0_addr(c0_addr), .c0_burst(c0_burst),
    .c0_waitreq(c0_waitreq), .c0_valid(c0_valid),
    .c1_rd(c1_rd), .c1_addr(c1_addr), .c1_burst(c1_burst),
    .c1_waitreq(c1_waitreq), .c1_valid(c1_valid),
    .cx_dout(cx_dout),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_din(dl_din), .dl_mask(dl_mask),
    .dl_waitreq(dl_waitreq),
    .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .ddr_addr(ddr_addr),
    .ddr_burst(ddr_burst), .ddr_din(ddr_din), .ddr_mask(ddr_mask),
    .ddr_dout(ddr_dout), .ddr_waitreq(ddr_waitreq), .ddr_valid(ddr_valid),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  assign rst_vec = {ddr_rd, ddr_wr, ddr_addr, ddr_burst, ddr_din, ddr_mask,
                    c0_waitreq, c1_waitreq, dl_waitreq, c0_valid, c1_valid,
                    dbg_state};
  assign rst_exp = {1'b0, 1'b0, 32'h0, 8'h0, 64'h0, 8'h0,
                    1'b1, 1'b1, DL_WAIT_RST, 1'b0, 1'b0, ST_IDLE};

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_sys) begin
    if (c0_valid || c1_valid) begin
      checks++;
      mon_got = {c1_valid, cx_dout};
      if (c0_valid && c1_valid) begin
        errors++;
        $display("FAIL beat_route: c0_valid and c1_valid both high, required one");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got client %0d data %h, required no beat",
                 c1_valid, cx_dout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL beat_data: got client %0d data %h, required client %0d data %h",
                   mon_got[DATA_W], mon_got[DATA_W-1:0], mon_exp[DATA_W], mon_exp[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk_sys);
    #1;
  endtask

  // Acts as DDR for one read: waits for ddr_rd, accepts it immediately,
  // checks the command, then returns nbeats beats (base, base+1, ...).
  // Verifies the return to IDLE only when the whole burst has been served.
  task automatic serve_read(input int cl, input logic [ADDR_W-1:0] a,
                            input int b, input int nbeats,
                            input logic [DATA_W-1:0] base, input bit drop,
                            output int lat);
    bit found;
    int eff;
    found = 1'b0;
    lat = -1;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      @(negedge clk_sys);
      if (ddr_rd) begin
        found = 1'b1;
        lat = cyc;
      end else begin
        next_cycle();
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rd_timeout: no ddr_rd within 20 cycles, required client %0d read", cl);
      return;
    end
    checks++;
    if (ddr_addr !== a || ddr_burst !== BURST_W'(b)) begin
      errors++;
      $display("FAIL rd_cmd: got addr %h burst %0d, required addr %h burst %0d",
               ddr_addr, ddr_burst, a, b);
    end
    checks++;
    if ({c1_waitreq, c0_waitreq} !== ((cl == 0) ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL rd_accept: got c1/c0 waitreq %b%b, required client %0d low",
               c1_waitreq, c0_waitreq, cl);
    end
    next_cycle();
    if (drop) begin
      c0_rd = 1'b0;
      c1_rd = 1'b0;
    end
    for (int i = 0; i < nbeats; i++) begin
      exp_q.push_back({cl[0], base + DATA_W'(i)});
      ddr_valid = 1'b1;
      ddr_dout  = base + DATA_W'(i);
      @(negedge clk_sys);
      checks++;
      if (dbg_state !== ST_RD_DATA || ddr_rd !== 1'b0) begin
        errors++;
        $display("FAIL rd_beat_state: beat %0d got state %0d ddr_rd %b, required state %0d ddr_rd 0",
                 i, dbg_state, ddr_rd, ST_RD_DATA);
      end
      if (i == 0) begin
        checks++;
        if ({c1_waitreq, c0_waitreq} !== 2'b11) begin
          errors++;
          $display("FAIL waitreq_release: got c1/c0 waitreq %b%b, required 11",
                   c1_waitreq, c0_waitreq);
        end
      end
      next_cycle();
    end
    ddr_valid = 1'b0;
    eff = (b == 0) ? 1 : b;
    if (nbeats == eff) begin
      @(negedge clk_sys);
      checks++;
      if (dbg_state !== ST_IDLE) begin
        errors++;
        $display("FAIL rd_done_idle: got state %0d, required %0d", dbg_state, ST_IDLE);
      end
      next_cycle();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk_sys);
    checks++;
    if (rst_vec !== rst_exp) begin
      errors++;
      $display("FAIL reset_values: got %h, required %h", rst_vec, rst_exp);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk_sys);
    checks++;
    if (rst_vec !== rst_exp) begin
      errors++;
      $display("FAIL reset_release_idle: got %h, required %h", rst_vec, rst_exp);
    end
    next_cycle();
  endtask

  task automatic test_fairness();
    int lat;
    int order[4] = '{0, 1, 0, 1};
    c0_addr = 32'h1000; c0_burst = 8'd1; c0_rd = 1'b1;
    c1_addr = 32'h2000; c1_burst = 8'd1; c1_rd = 1'b1;
    next_cycle();
    for (int t = 0; t < 4; t++) begin
      serve_read(order[t], (order[t] == 0) ? 32'h1000 : 32'h2000, 1, 1,
                 64'h100 + 64'(t), (t == 3), lat);
      checks++;
      if (lat !== 0) begin
        errors++;
        $display("FAIL fair_latency: transaction %0d strobe after %0d cycles, required 0", t, lat);
      end
    end
  endtask

  task automatic test_single_read();
    int lat;
    c0_addr = 32'h100; c0_burst = 8'd4; c0_rd = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (ddr_rd !== 1'b0 || c0_waitreq !== 1'b1) begin
      errors++;
      $display("FAIL single_req_cycle: got ddr_rd %b c0_waitreq %b, required 0 1", ddr_rd, c0_waitreq);
    end
    next_cycle();
    serve_read(0, 32'h100, 4, 4, 64'd1, 1'b1, lat);
    checks++;
    if (lat !== 0) begin
      errors++;
      $display("FAIL single_latency: strobe %0d cycles late, required T+1", lat);
    end
  endtask

  task automatic test_read_stall();
    int lat;
    c1_addr = 32'h4444; c1_burst = 8'd2; c1_rd = 1'b1;
    ddr_waitreq = 1'b1;
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      checks++;
      if (ddr_rd !== 1'b1 || ddr_addr !== 32'h4444 || ddr_burst !== 8'd2 ||
          c1_waitreq !== 1'b1 || c0_waitreq !== 1'b1 || dbg_state !== ST_RD_REQ) begin
        errors++;
        $display("FAIL rd_stall_hold: cycle %0d got rd %b addr %h burst %0d wr %b%b state %0d, required 1 4444 2 11 %0d",
                 k, ddr_rd, ddr_addr, ddr_burst, c1_waitreq, c0_waitreq, dbg_state, ST_RD_REQ);
      end
      next_cycle();
    end
    ddr_waitreq = 1'b0;
    serve_read(1, 32'h4444, 2, 2, 64'h50, 1'b1, lat);
  endtask

`ifdef DDR_ARB_DOWNLOAD_EN
  task automatic test_priority();
    int lat;
    dl_wr = 1'b1; dl_addr = 32'h2000; dl_din = 64'hDEADBEEF; dl_mask = 8'hFF;
    c1_addr = 32'h3000; c1_burst = 8'd1; c1_rd = 1'b1;
    ddr_waitreq = 1'b1;
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      checks++;
      if (ddr_wr !== 1'b1 || ddr_rd !== 1'b0 || ddr_addr !== 32'h2000 ||
          ddr_din !== 64'hDEADBEEF || ddr_mask !== 8'hFF || ddr_burst !== 8'd1 ||
          dl_waitreq !== 1'b1 || c1_waitreq !== 1'b1) begin
        errors++;
        $display("FAIL wr_stall_hold: cycle %0d got wr %b rd %b addr %h din %h mask %h burst %0d dlw %b, required 1 0 2000 deadbeef ff 1 1",
                 k, ddr_wr, ddr_rd, ddr_addr, ddr_din, ddr_mask, ddr_burst, dl_waitreq);
      end
      next_cycle();
    end
    ddr_waitreq = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (dl_waitreq !== 1'b0 || ddr_wr !== 1'b1 || c1_waitreq !== 1'b1) begin
      errors++;
      $display("FAIL wr_accept: got dl_waitreq %b ddr_wr %b c1_waitreq %b, required 0 1 1",
               dl_waitreq, ddr_wr, c1_waitreq);
    end
    next_cycle();
    dl_wr = 1'b0;
    serve_read(1, 32'h3000, 1, 1, 64'h77, 1'b1, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL wr_then_rd_gap: read strobe %0d cycles after IDLE start, required 1", lat);
    end
  endtask
`else
  task automatic test_no_download();
    dl_wr = 1'b1; dl_addr = 32'h2000; dl_din = 64'hDEADBEEF; dl_mask = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      checks++;
      if (dl_waitreq !== 1'b0 || ddr_wr !== 1'b0 || ddr_din !== 64'h0 ||
          ddr_mask !== 8'h0 || ddr_rd !== 1'b0 || dbg_state !== ST_IDLE) begin
        errors++;
        $display("FAIL no_dl_drop: cycle %0d got dlw %b wr %b din %h mask %h rd %b state %0d, required 0 0 0 0 0 0",
                 k, dl_waitreq, ddr_wr, ddr_din, ddr_mask, ddr_rd, dbg_state);
      end
      next_cycle();
    end
    dl_wr = 1'b0;
  endtask
`endif

  task automatic test_bursts();
    int lat;
    c0_addr = 32'h800; c0_burst = 8'd0; c0_rd = 1'b1;
    next_cycle();
    serve_read(0, 32'h800, 0, 1, 64'hA0, 1'b1, lat);
    c1_addr = 32'h900; c1_burst = 8'd255; c1_rd = 1'b1;
    next_cycle();
    serve_read(1, 32'h900, 255, 255, 64'h1000, 1'b1, lat);
    ddr_valid = 1'b1;
    ddr_dout  = 64'hBAD;
    @(negedge clk_sys);
    checks++;
    if (c0_valid !== 1'b0 || c1_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_stray_beat: got valids %b%b, required 00", c1_valid, c0_valid);
    end
    next_cycle();
    ddr_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    c0_addr = 32'h700; c0_burst = 8'd4; c0_rd = 1'b1;
    next_cycle();
    serve_read(0, 32'h700, 4, 2, 64'h90, 1'b1, lat);
    rst_n = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (rst_vec !== rst_exp) begin
      errors++;
      $display("FAIL reset_mid_values: got %h, required %h", rst_vec, rst_exp);
    end
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ddr_valid = 1'b1;
      ddr_dout  = 64'hEE + 64'(k);
      @(negedge clk_sys);
      checks++;
      if (c0_valid !== 1'b0 || c1_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
        errors++;
        $display("FAIL reset_stray_beat: beat %0d got valids %b%b state %0d, required 00 0",
                 k, c1_valid, c0_valid, dbg_state);
      end
      next_cycle();
    end
    ddr_valid = 1'b0;
  endtask

  // The last read before the reset went to client 0; after reset the first
  // tie must still go to client 0.
  task automatic test_tie_after_reset();
    int lat;
    c0_addr = 32'hC000 + 32'($urandom_range(0, 255)); c0_burst = 8'd1; c0_rd = 1'b1;
    c1_addr = 32'hD000; c1_burst = 8'd1; c1_rd = 1'b1;
    next_cycle();
    serve_read(0, c0_addr, 1, 1, 64'h5A, 1'b1, lat);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fairness();
    test_single_read();
    test_read_stall();
`ifdef DDR_ARB_DOWNLOAD_EN
    test_priority();
`else
    test_no_download();
`endif
    test_bursts();
    test_reset_mid();
    test_tie_after_reset();
    repeat (2) next_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL beats_missing: %0d expected beats never seen, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_arbiter.md
# ddr_arbiter

Shares the single DDR3 Avalon-style port between two burst-read clients (client 0: 68k program ROM fetch; client 1: graphics/sprite ROM fetch) and the ROM download write channel. Sits in the fast `clk_sys` domain between the client-facing cache/fetch units and the top-level DDRAM pins. It serialises transactions with a registered grant, and routes returning read beats to the granted client.

## Interface
- `ADDR_W`, 32, byte address width on all ports.
- `DATA_W`, 64, data width on all ports.
- `BURST_W`, 8, burst count width.
- `clk_sys`  in  1  system clock; all logic is single-clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `c0_rd`, `c1_rd`  in  1  read request; held until the client's waitreq is low.
- `c0_addr`, `c1_addr`  in  ADDR_W  read start address; held with request.
- `c0_burst`, `c1_burst`  in  BURST_W  beats requested; 0 is treated as 1.
- `c0_waitreq`, `c1_waitreq`  out  1  low for exactly the acceptance cycle.
- `c0_valid`, `c1_valid`  out  1  read beat valid for this client.
- `cx_dout`  out  DATA_W  shared read data bus; it equals `ddr_dout`.
- `dl_wr`  in  1  download write request; single beat.
- `dl_addr`  in  ADDR_W  write address.
- `dl_din`  in  DATA_W  write data.
- `dl_mask`  in  DATA_W/8  byte enables.
- `dl_waitreq`  out  1  low for exactly the acceptance cycle.
- `ddr_rd`, `ddr_wr`  out  1  DDR command strobes.
- `ddr_addr`  out  ADDR_W  DDR address.
- `ddr_burst`  out  BURST_W  DDR burst count; it is 1 for writes.
- `ddr_din`  out  DATA_W  DDR write data.
- `ddr_mask`  out  DATA_W/8  DDR byte enables.
- `ddr_dout`  in  DATA_W  DDR read data.
- `ddr_waitreq`  in  1  DDR busy; a command is accepted when it is high-strobe and `ddr_waitreq` is low.
- `ddr_valid`  in  1  DDR read beat valid.

## Operation
- FSM states: IDLE, RD_REQ, RD_DATA, WR_REQ.
- IDLE arbitration is evaluated every cycle:
  - `dl_wr` has the highest priority.
  - Otherwise, if both read clients are requesting, the client not granted last time wins.
  - Otherwise, the single requesting client wins.
  - The winner's address, burst and data are latched into registers, `grant` is registered, and the FSM moves to RD_REQ or WR_REQ.
- RD_REQ: `ddr_rd`=1 with the latched address and burst. On `~ddr_waitreq`:
  - the granted client's waitreq is driven 0 that cycle;
  - the beat counter is loaded with the burst value (0 is replaced by 1);
  - the FSM moves to RD_DATA;
  - `last_grant` is updated.
- RD_DATA: each `ddr_valid` beat does two things:
  - pulses `cN_valid` for the granted client (combinational from `ddr_valid`);
  - decrements the counter.
  - On the beat with counter==1, the FSM returns to IDLE.
- WR_REQ: `ddr_wr`=1 with the latched address, data and mask, and `ddr_burst`=1. On `~ddr_waitreq`, `dl_waitreq` is driven 0 that cycle and the FSM returns to IDLE.
- `ddr_valid` outside RD_DATA is ignored; no client valid is asserted.
- Client waitreq lines are 1 in every cycle except their own acceptance cycle.
- A client dropping its request before acceptance is a protocol violation. The latched command still completes, and its data is routed to that client.
- Reads are starved while downloads are present. This is intentional, because the CPU is held in reset during download.

## Timing
- Reset values:
  - FSM=IDLE, `ddr_rd`=`ddr_wr`=0, address, burst, data and mask registers =0.
  - `c0_waitreq`=`c1_waitreq`=`dl_waitreq`=1, all `cN_valid`=0, `last_grant`=client 1 (so client 0 wins the first tie).
- Grant latency: a request seen in IDLE at cycle T produces the DDR strobe at T+1. Acceptance is at the earliest T+1, with the client waitreq low in the same cycle.
- Back-to-back: the cycle after the final read beat or write acceptance is IDLE. The next DDR strobe is therefore at least 2 cycles after the previous acceptance or final beat.
- Command outputs are held stable while `ddr_waitreq`=1.
- Reset asserted mid-transaction:
  - all state clears immediately;
  - DDR beats still in flight after reset release are discarded, since they arrive in IDLE.
- The beat counter is BURST_W bits. A burst of 255 must complete with no wrap.

## Configuration
- `DDR_ARB_DOWNLOAD_EN` defined: the write channel, the WR_REQ state and download priority are compiled in as described above.
- `DDR_ARB_DOWNLOAD_EN` undefined:
  - WR_REQ is absent, `ddr_wr` is constant 0, `ddr_din` and `ddr_mask` are constant 0;
  - `dl_*` inputs are ignored and `dl_waitreq` is constant 0, so writes are dropped without stalling;
  - the ports remain present.

## Test plan
- Single read: `c0_rd`, addr 0x100, burst 4, `ddr_waitreq`=0, 4 `ddr_valid` beats with data 1..4 -> `ddr_rd` rises at T+1 with addr 0x100 and burst 4, `c0_waitreq` is low at T+1 only, `c0_valid` pulses 4 times with data 1..4, `c1_valid` stays 0, and the FSM is IDLE after beat 4.
- Fairness: `c0_rd` and `c1_rd` held continuously, burst 1 each -> grants alternate 0,1,0,1 over 4 transactions.
- Priority and stall: `dl_wr` (addr 0x2000, data 0xDEADBEEF, mask 0xFF) together with `c1_rd`, and `ddr_waitreq`=1 for 3 cycles -> the write is issued first; `ddr_wr` and its data are held stable for those 3 cycles; `dl_waitreq` goes low on the 4th cycle; then the c1 read issues.
- Burst 0 and burst 255: burst 0 completes after 1 beat; burst 255 completes after exactly 255 beats with no early exit.
- Reset mid-burst: `rst_n` is pulsed low after beat 2 of 4, then 2 stray `ddr_valid` beats arrive -> all outputs return to their reset values and no `cN_valid` is asserted.
- Without `DDR_ARB_DOWNLOAD_EN`: `dl_wr` pulsed -> `dl_waitreq`=0 and `ddr_wr` never asserts.
